bcd_seq_ctrl: RTL and testbench

Multi-cycle binary-to-BCD conversion controller. It accepts an 11-bit unsigned value through a start/ready handshake and sequences an iterative double-dabble (shift-and-add-3) datapath, one bit per cycle. It returns a registered 4-digit packed BCD result with a one-cycle done pulse. It is the area-lean, sequenced replacement for the fully combinational 11-bit BCD converter and feeds the seven-segment display path.

---
 rtl/bcd_seq_pkg.sv | 26 ++
 rtl/bcd_add3.sv | 14 +
 rtl/bcd_seq_ctrl.sv | 116 +++++++++++
 tb/tb_bcd_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seq_pkg.sv
// Shared types and constants for the sequenced binary-to-BCD converter.
// Holds the FSM state encoding, default geometry and the per-digit correction helper.
package bcd_seq_pkg;

    localparam int BCD_IN_W   = 11;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_CNT_W  = $clog2(BCD_IN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Double-dabble digit correction: a digit of 5..9 would exceed 9 after doubling.
    function automatic logic [3:0] dabble_fix(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd5) begin
            r = d + 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational add-3 correction for one BCD digit (no carry to neighbours).
module bcd_add3
    import bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Per-digit correction applied before each shift.
    always_comb begin
        dout = dabble_fix(din);
    end

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequenced binary-to-BCD controller: one double-dabble step per clock, start/ready in, done pulse out.
// Optional leading-zero blanking output enabled by defining BCD_SEQ_BLANK_EN.
module bcd_seq_ctrl
    import bcd_seq_pkg::*;
#(
    parameter int IN_W   = BCD_IN_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_SEQ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t             state_r;
    logic [IN_W-1:0]    op_r;
    logic [BW-1:0]      work_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BW-1:0]      fix_s;
    logic [BW-1:0]      work_shift_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (work_r[4*g +: 4]),
            .dout (fix_s[4*g +: 4])
        );
    end

    // Corrected working value shifted left, pulling in the operand MSB.
    always_comb begin
        work_shift_s = {fix_s[BW-2:0], op_r[IN_W-1]};
    end

`ifdef BCD_SEQ_BLANK_EN
    logic [DIGITS-1:0] blank_next_s;
    logic              zero_above_s;

    // Digit i blanks only when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        blank_next_s = {DIGITS{1'b0}};
        zero_above_s = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above_s    = zero_above_s & (work_shift_s[4*i +: 4] == 4'd0);
            blank_next_s[i] = zero_above_s;
        end
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            op_r    <= {IN_W{1'b0}};
            work_r  <= {BW{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ready   <= 1'b1;
            done    <= 1'b0;
            bcd     <= {BW{1'b0}};
`ifdef BCD_SEQ_BLANK_EN
            blank   <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r    <= bin;
                        work_r  <= {BW{1'b0}};
                        cnt_r   <= CNT_W'(IN_W);
                        ready   <= 1'b0;
                        state_r <= SHIFT;
                    end else begin
                        ready   <= 1'b1;
                    end
                end
                SHIFT: begin
                    op_r   <= {op_r[IN_W-2:0], 1'b0};
                    work_r <= work_shift_s;
                    cnt_r  <= cnt_r - CNT_W'(1);
                    // The last step's result is published straight into the output register.
                    if (cnt_r == CNT_W'(1)) begin
                        bcd     <= work_shift_s;
`ifdef BCD_SEQ_BLANK_EN
                        blank   <= blank_next_s;
`endif
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done    <= 1'b0;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Self-checking bench for bcd_seq_ctrl: vector table, random conversions, corner sequences and a held-start sweep.
// Expected results come from a decimal-arithmetic model; blank is checked when BCD_SEQ_BLANK_EN is defined.
module tb_bcd_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] bin;
    logic        ready;
    logic        done;
    logic [15:0] bcd;
`ifdef BCD_SEQ_BLANK_EN
    logic [3:0]  blank;
`endif

    int checks;
    int passes;

    bcd_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .bcd   (bcd)
`ifdef BCD_SEQ_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          val;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_blank;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [15:0] model_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [3:0] model_blank(input int v);
        logic [3:0] b;
        b = 4'b0000;
        if (v < 1000) b[3] = 1'b1;
        if (v < 100)  b[2] = 1'b1;
        if (v < 10)   b[1] = 1'b1;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for ready at a falling edge, then issue a one-cycle start; returns at the negedge of cycle 1.
    task automatic accept(input int v);
        int n;
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_start", 32'(ready), 32'd1);
        start = 1'b1;
        bin   = 11'(v);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = 11'($urandom_range(0, 2047));
    endtask

    // Full conversion: latency, ready during SHIFT, result and return to idle.
    task automatic run_conv(input int v, input logic [15:0] eb, input logic [3:0] ebl);
        int  lat;
        logic bad_ready;
        accept(v);
        lat = 0;
        bad_ready = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (ready) bad_ready = 1'b1;
            @(negedge clk);
        end
        chk($sformatf("latency_%0d", v), 32'(lat), 32'd12);
        chk($sformatf("ready_low_%0d", v), 32'(bad_ready), 32'd0);
        chk($sformatf("bcd_%0d", v), 32'(bcd), 32'(eb));
`ifdef BCD_SEQ_BLANK_EN
        chk($sformatf("blank_%0d", v), 32'(blank), 32'(ebl));
`else
        if (ebl === 4'bxxxx) $display("unused blank value");
`endif
        @(negedge clk);
        chk($sformatf("done_drop_%0d", v), 32'(done), 32'd0);
        chk($sformatf("ready_back_%0d", v), 32'(ready), 32'd1);
    endtask

    initial begin
        int          dcount;
        int          first_lat;
        logic [15:0] first_bcd;
        int          q[$];
        int          nextv;
        int          cyc;
        int          last_done;
        int          ready_cnt;
        int          got;
        int          ev;

        checks = 0;
        passes = 0;

        vecs[0] = '{0,    16'h0000, 4'b1110};
        vecs[1] = '{2047, 16'h2047, 4'b0000};
        vecs[2] = '{5,    16'h0005, 4'b1110};
        vecs[3] = '{10,   16'h0010, 4'b1100};
        vecs[4] = '{100,  16'h0100, 4'b1000};
        vecs[5] = '{1000, 16'h1000, 4'b0000};
        vecs[6] = '{999,  16'h0999, 4'b1000};
        vecs[7] = '{1234, 16'h1234, 4'b0000};

        start = 1'b0;
        bin   = 11'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'h0000);
`ifdef BCD_SEQ_BLANK_EN
        chk("rst_blank", 32'(blank), 32'(4'b1110));
`endif

        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].val, vecs[i].exp_bcd, vecs[i].exp_blank);
        end

        for (int i = 0; i < 25; i++) begin
            int v;
            v = int'($urandom_range(0, 2047));
            run_conv(v, model_bcd(v), model_blank(v));
        end

        // Second start during SHIFT must be ignored.
        accept(999);
        dcount = 0;
        first_lat = 0;
        first_bcd = 16'h0000;
        for (int n = 1; n <= 30; n++) begin
            if (n == 5) begin
                start = 1'b1;
                bin   = 11'd1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    first_lat = n;
                    first_bcd = bcd;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("ignore_done_count", 32'(dcount), 32'd1);
        chk("ignore_latency", 32'(first_lat), 32'd12);
        chk("ignore_bcd", 32'(first_bcd), 32'h0999);

        // Reset mid-conversion aborts with no done pulse and clears bcd.
        accept(1234);
        for (int n = 1; n < 6; n++) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_bcd", 32'(bcd), 32'h0000);
        chk("abort_done", 32'(done), 32'd0);
        dcount = 0;
        for (int n = 0; n < 20; n++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(dcount), 32'd0);

        // Held-start sweep over the full input range.
        start     = 1'b1;
        bin       = 11'd0;
        q.push_back(0);
        nextv     = 1;
        cyc       = 0;
        last_done = 0;
        ready_cnt = 1;
        got       = 0;
        while (got < 2048 && cyc < 2048 * 13 + 100) begin
            @(negedge clk);
            cyc++;
            if (ready) begin
                ready_cnt++;
                if (nextv <= 2047) begin
                    bin = 11'(nextv);
                    q.push_back(nextv);
                    nextv++;
                end
            end
            if (done) begin
                if (q.size() > 0) begin
                    ev = q.pop_front();
                    chk($sformatf("sweep_bcd_%0d", ev), 32'(bcd), 32'(model_bcd(ev)));
                end else begin
                    chk("sweep_spurious_done", 32'd1, 32'(q.size()));
                end
                if (got > 0) chk("sweep_period", 32'(cyc - last_done), 32'd13);
                chk("sweep_ready_once", 32'(ready_cnt), 32'd1);
                ready_cnt = 0;
                last_done = cyc;
                got++;
            end
        end
        start = 1'b0;
        chk("sweep_count", 32'(got), 32'd2048);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
